// File: rtl/perf_report_pkg.sv
// perf_report_pkg
//   Shared types and constants for the performance-report UART block:
//   FSM state encoding, report length, ASCII codes used by the fixed
//   report line, and a nibble-to-hex-ASCII helper.
package perf_report_pkg;

    // Report sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        LOAD,
        START,
        DATA,
        STOP,
        FINISH
    } report_state_t;

    // Report line: 'C' '=' H7..H0 ' ' 'T' '=' D3..D0 CR LF
    localparam int MSG_LEN = 19;

    // Width of the hundredths-of-second input and of its 4-digit BCD form.
    localparam int HUND_W = 13;
    localparam int BCD_W  = 16;

    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_EQ = 8'h3D;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/bin2bcd_13.sv
// bin2bcd_13
//   Sequential double-dabble converter for a 13-bit binary value
//   (0..8191) into four BCD digits. One shift/adjust step per clock,
//   13 steps in total. The first step is taken in the start cycle
//   directly on 'bin', so the result is complete at the clock edge that
//   ends the cycle in which 'done' is high (13 cycles after start rises).
//
// Ports
//   CLK_50  clock
//   resetN  asynchronous active-low reset
//   start   one-cycle pulse; 'bin' is sampled in this cycle
//   bin     binary input value
//   bcd     {thousands, hundreds, tens, units}, valid after the done cycle
//   done    high during the 13th (last) conversion cycle
module bin2bcd_13
    import perf_report_pkg::*;
(
    input  logic              CLK_50,
    input  logic              resetN,
    input  logic              start,
    input  logic [HUND_W-1:0] bin,
    output logic [BCD_W-1:0]  bcd,
    output logic              done
);

    logic [HUND_W-1:0]       bin_sh;
    logic [3:0]              iter;
    logic                    active;
    logic [BCD_W+HUND_W-1:0] stage;

    // One double-dabble step: add 3 to every digit >= 5, then shift the
    // combined {digits, remaining binary} left by one.
    function automatic logic [BCD_W+HUND_W-1:0] dabble_step(
        input logic [BCD_W-1:0]  digits,
        input logic [HUND_W-1:0] rest
    );
        logic [BCD_W-1:0] adj;
        for (int d = 0; d < BCD_W / 4; d++) begin
            adj[4*d +: 4] = (digits[4*d +: 4] >= 4'd5) ? digits[4*d +: 4] + 4'd3
                                                       : digits[4*d +: 4];
        end
        return {adj, rest} << 1;
    endfunction

    // The start cycle works on the fresh input with cleared digits.
    always_comb begin
        stage = start ? dabble_step('0, bin) : dabble_step(bcd, bin_sh);
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            bcd    <= '0;
            bin_sh <= '0;
            iter   <= '0;
            active <= 1'b0;
        end else if (start) begin
            {bcd, bin_sh} <= stage;
            iter          <= 4'd1;
            active        <= 1'b1;
        end else if (active) begin
            {bcd, bin_sh} <= stage;
            iter          <= iter + 4'd1;
            if (iter == 4'(HUND_W - 1))
                active <= 1'b0;
        end
    end

    // Steps 2..13 run while active; the 13th step happens at the end of
    // the cycle where iter == 12.
    assign done = active && (iter == 4'(HUND_W - 1));

endmodule

// File: rtl/perf_uart_report.sv
// perf_uart_report
//   Sends one fixed-format ASCII report line over an 8N1 UART whenever the
//   performance counter signals completion (rising edge of 'finished'), or
//   when a resend is requested. Line format (19 bytes):
//     "C=" + 8 uppercase hex digits of cycle_count + " T=" +
//     4 decimal digits of hund_seconds + CR LF
//
// Ports
//   CLK_50        system clock
//   resetN        asynchronous active-low reset
//   finished      sticky completion flag from the performance counter
//   cycle_count   32-bit clock count (frozen once finished)
//   hund_seconds  13-bit hundredths-of-second count (saturates at 8191)
//   send_req      one-cycle pulse: resend the last captured values
//   uart_tx       registered serial output, idle high
//   busy          high from trigger until the last stop bit ends
//   report_done   one-cycle pulse in the final (FINISH) cycle of a report
module perf_uart_report
    import perf_report_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic              CLK_50,
    input  logic              resetN,
    input  logic              finished,
    input  logic [31:0]       cycle_count,
    input  logic [HUND_W-1:0] hund_seconds,
    input  logic              send_req,
    output logic              uart_tx,
    output logic              busy,
    output logic              report_done
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [4:0]       IDX_LAST  = 5'(MSG_LEN - 1);

    report_state_t     state;
    logic              finished_q;
    logic [31:0]       cap_cycles;
    logic [HUND_W-1:0] cap_hund;
    logic [4:0]        idx;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        tx_shift;
    logic              bcd_start;
    logic              bcd_done;
    logic [BCD_W-1:0]  bcd;

    logic              fin_rise;
    logic              trig;
    logic              baud_tick;
    logic [7:0]        msg_byte;
    logic [2:0]        hex_pos;
    logic [1:0]        dig_pos;
    logic [3:0]        hex_nib;
    logic [3:0]        dig_nib;

    assign fin_rise  = finished & ~finished_q;
    assign trig      = fin_rise | send_req;
    assign baud_tick = (baud_cnt == BAUD_LAST);

    bin2bcd_13 u_bin2bcd (
        .CLK_50 (CLK_50),
        .resetN (resetN),
        .start  (bcd_start),
        .bin    (cap_hund),
        .bcd    (bcd),
        .done   (bcd_done)
    );

    // Message byte selected by idx. Hex digits run MSB nibble first
    // (idx 2 -> bits 31:28), decimal digits thousands first (idx 13).
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        hex_pos  = 3'(5'd9 - idx);
        dig_pos  = 2'(5'd16 - idx);
        hex_nib  = 4'(cap_cycles >> {hex_pos, 2'b00});
        dig_nib  = 4'(bcd >> {dig_pos, 2'b00});
        msg_byte = CH_LF;
        case (idx) inside
            5'd0:           msg_byte = CH_C;
            5'd1:           msg_byte = CH_EQ;
            [5'd2:5'd9]:    msg_byte = hex2ascii(hex_nib);
            5'd10:          msg_byte = CH_SP;
            5'd11:          msg_byte = CH_T;
            5'd12:          msg_byte = CH_EQ;
            [5'd13:5'd16]:  msg_byte = {4'h3, dig_nib};
            5'd17:          msg_byte = CH_CR;
            default:        msg_byte = CH_LF;
        endcase
    end

    // Report sequencer. All outputs are registered: each state's line level
    // is written on the edge that enters it, so uart_tx never depends
    // combinationally on the inputs.
    // NOTE: the captured values are data registers but are still reset, so
    // a resend request before any capture reports all zeros.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            finished_q  <= 1'b0;
            cap_cycles  <= '0;
            cap_hund    <= '0;
            idx         <= '0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            tx_shift    <= '0;
            bcd_start   <= 1'b0;
            uart_tx     <= 1'b1;
            busy        <= 1'b0;
            report_done <= 1'b0;
        end else begin
            finished_q  <= finished;
            bcd_start   <= 1'b0;
            report_done <= 1'b0;

            case (state)
                IDLE: begin
                    // Triggers are only looked at here, so anything arriving
                    // while a report is running is dropped, not queued.
                    if (trig) begin
                        if (fin_rise) begin
                            cap_cycles <= cycle_count;
                            cap_hund   <= hund_seconds;
                        end
                        bcd_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end

                CONVERT: begin
                    if (bcd_done) begin
                        idx   <= '0;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    baud_cnt <= '0;
                    tx_shift <= msg_byte;
                    uart_tx  <= 1'b0;
                    state    <= START;
                end

                START: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            uart_tx  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            bit_idx  <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (baud_tick) begin
                        baud_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            report_done <= 1'b1;
                            busy        <= 1'b0;
                            state       <= FINISH;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= LOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perf_uart_report.sv
// tb_perf_uart_report
//   Directed bench for perf_uart_report. The DUT runs with a 10-cycle
//   bit period so several full reports fit in a short run; a UART
//   receiver task decodes the line at mid-bit and the decoded text is
//   compared with hand-written expected report lines.
module tb_perf_uart_report;

    localparam int TB_CLK_FREQ = 1_000_000;
    localparam int TB_BAUD     = 100_000;
    localparam int B           = TB_CLK_FREQ / TB_BAUD;   // 10 cycles per bit
    localparam int X           = 10 * B + 1;              // cycles per byte incl. LOAD
    localparam int TMO         = 4 * B + 40;

    logic        CLK_50 = 1'b0;
    logic        resetN;
    logic        finished;
    logic [31:0] cycle_count;
    logic [12:0] hund_seconds;
    logic        send_req;
    logic        uart_tx;
    logic        busy;
    logic        report_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy = 1'b1;

    perf_uart_report #(
        .CLK_FREQ (TB_CLK_FREQ),
        .BAUD     (TB_BAUD)
    ) dut (
        .CLK_50       (CLK_50),
        .resetN       (resetN),
        .finished     (finished),
        .cycle_count  (cycle_count),
        .hund_seconds (hund_seconds),
        .send_req     (send_req),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .report_done  (report_done)
    );

    always #5 CLK_50 = ~CLK_50;

    always @(posedge CLK_50) cyc = cyc + 1;

    always @(negedge CLK_50) begin
        if (report_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Receive one 8N1 byte. Called on a negedge; if in_start is set the
    // caller has just seen the first low cycle of the start bit.
    task automatic recv_byte(input bit in_start, output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1;
        b  = '0;
        if (!in_start) begin
            n = 0;
            while (uart_tx !== 1'b0 && n < TMO) begin
                @(negedge CLK_50);
                n++;
            end
            if (uart_tx !== 1'b0) begin
                ok = 1'b0;
                return;
            end
        end
        repeat (B / 2) @(negedge CLK_50);
        if (uart_tx !== 1'b0) ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            repeat (B) @(negedge CLK_50);
            b[k] = uart_tx;
        end
        repeat (B) @(negedge CLK_50);
        if (uart_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic recv_report(input bit in_start, output string got, output bit ok);
        logic [7:0] b;
        bit         bok;
        got = "";
        ok  = 1'b1;
        for (int i = 0; i < 19; i++) begin
            recv_byte(in_start && (i == 0), b, bok);
            if (!bok) begin
                ok = 1'b0;
                break;
            end
            got = $sformatf("%s%c", got, b);
        end
    endtask

    task automatic wait_done(input int prev, output bit ok);
        int n;
        n = 0;
        while (done_cnt == prev && n < TMO) begin
            @(negedge CLK_50);
            n++;
        end
        ok = (done_cnt != prev);
    endtask

    // Count cycles with line activity over a quiet window.
    task automatic quiet_window(input int len, output int active);
        active = 0;
        repeat (len) begin
            @(negedge CLK_50);
            if (uart_tx !== 1'b1 || busy !== 1'b0) active++;
        end
    endtask

    task automatic test_reset();
        int bad;
        resetN = 1'b0; finished = 1'b0; send_req = 1'b0;
        cycle_count = '0; hund_seconds = '0;
        repeat (5) @(negedge CLK_50);
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", uart_tx); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (report_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", report_done); end
        resetN = 1'b1;
        quiet_window(1000, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_line active cycles %0d want 0", bad); end
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL idle_done pulses %0d want 0", done_cnt); end
    endtask

    task automatic test_basic();
        string got;
        bit    ok;
        int    t0, prev;
        prev = done_cnt;
        cycle_count = 32'h0001E240; hund_seconds = 13'd1234; finished = 1'b1;
        @(posedge CLK_50);              // trigger sampled here
        @(negedge CLK_50);
        t0 = cyc;
        repeat (13) @(negedge CLK_50);  // 14th cycle after trigger: LOAD
        checks++;
        if (uart_tx !== 1'b1) begin errors++; $display("FAIL basic_early_start tx %b want 1", uart_tx); end
        @(negedge CLK_50);              // 15th cycle after trigger: start bit
        checks++;
        if (uart_tx !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL basic_start_latency tx %b busy %b want 0 1", uart_tx, busy);
        end
        recv_report(1'b1, got, ok);
        checks++;
        if (!ok || got != "C=0001E240 T=1234\015\012") begin
            errors++; $display("FAIL basic_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        repeat (5) @(negedge CLK_50);
        checks++;
        if (!ok || done_cnt != prev + 1) begin
            errors++; $display("FAIL basic_done_count got %0d want %0d", done_cnt - prev, 1);
        end
        // report_done is visible 13 + 19*X edges after the trigger edge,
        // i.e. in the last of the 15 + 19*X report cycles.
        checks++;
        if (done_cyc - t0 != 13 + 19 * X) begin
            errors++; $display("FAIL basic_done_time got %0d want %0d", done_cyc - t0, 13 + 19 * X);
        end
        checks++;
        if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", done_busy); end
    endtask

    task automatic test_max_and_small();
        string got;
        bit    ok;
        int    prev;
        finished = 1'b0;
        repeat (3) @(negedge CLK_50);
        prev = done_cnt;
        cycle_count = 32'hFFFFFFFF; hund_seconds = 13'd8191; finished = 1'b1;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=FFFFFFFF T=8191\015\012") begin
            errors++; $display("FAIL max_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        finished = 1'b0;
        repeat (3) @(negedge CLK_50);
        cycle_count = 32'h00ABCDEF; hund_seconds = 13'd7; finished = 1'b1;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=00ABCDEF T=0007\015\012") begin
            errors++; $display("FAIL small_msg ok %0d got %s", ok, got);
        end
        wait_done(prev + 1, ok);
        checks++;
        if (!ok || done_cnt != prev + 2) begin
            errors++; $display("FAIL max_small_done got %0d want 2", done_cnt - prev);
        end
    endtask

    task automatic test_busy_ignore();
        string got;
        bit    ok;
        int    prev, act;
        finished = 1'b0;
        repeat (3) @(negedge CLK_50);
        prev = done_cnt;
        cycle_count = 32'hDEADBEEF; hund_seconds = 13'd42; finished = 1'b1;
        fork
            recv_report(1'b0, got, ok);
            begin
                repeat (600) @(negedge CLK_50);
                send_req = 1'b1;
                @(negedge CLK_50);
                send_req = 1'b0;
            end
        join
        checks++;
        if (!ok || got != "C=DEADBEEF T=0042\015\012") begin
            errors++; $display("FAIL busy_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        quiet_window(3 * X, act);       // finished held high, no new edge
        checks++;
        if (act != 0 || done_cnt != prev + 1) begin
            errors++; $display("FAIL busy_no_second active %0d reports %0d want 0 1", act, done_cnt - prev);
        end
    endtask

    task automatic test_resend();
        string got;
        bit    ok;
        int    prev;
        prev = done_cnt;
        // Live inputs change, but a resend must reuse the captured values.
        cycle_count = 32'h11111111; hund_seconds = 13'd1;
        send_req = 1'b1;
        @(negedge CLK_50);
        send_req = 1'b0;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=DEADBEEF T=0042\015\012") begin
            errors++; $display("FAIL resend_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL resend_done got %0d want 1", done_cnt - prev); end
    endtask

    task automatic test_simultaneous();
        string got;
        bit    ok;
        int    prev, act;
        finished = 1'b0;
        repeat (3) @(negedge CLK_50);
        prev = done_cnt;
        cycle_count = 32'h0BADF00D; hund_seconds = 13'd5000;
        finished = 1'b1; send_req = 1'b1;
        @(negedge CLK_50);
        send_req = 1'b0;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=0BADF00D T=5000\015\012") begin
            errors++; $display("FAIL simul_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        quiet_window(3 * X, act);
        checks++;
        if (act != 0 || done_cnt != prev + 1) begin
            errors++; $display("FAIL simul_single active %0d reports %0d want 0 1", act, done_cnt - prev);
        end
    endtask

    task automatic test_reset_mid_frame();
        string got;
        bit    ok;
        int    prev, act;
        finished = 1'b0;
        repeat (3) @(negedge CLK_50);
        prev = done_cnt;
        // Byte 5 is hex digit '0' (0x30): data bit 0 drives the line low.
        cycle_count = 32'h12300000; hund_seconds = 13'd3; finished = 1'b1;
        @(posedge CLK_50);
        repeat (14 + 5 * X + B + B / 2) @(posedge CLK_50);
        #2;
        checks++;
        if (uart_tx !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL midrst_pre tx %b busy %b want 0 1", uart_tx, busy);
        end
        resetN = 1'b0;
        finished = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || report_done !== 1'b0) begin
            errors++; $display("FAIL midrst_async tx %b busy %b done %b want 1 0 0", uart_tx, busy, report_done);
        end
        repeat (3) @(negedge CLK_50);
        resetN = 1'b1;
        quiet_window(2 * X, act);
        checks++;
        if (act != 0 || done_cnt != prev) begin
            errors++; $display("FAIL midrst_no_resume active %0d reports %0d want 0 0", act, done_cnt - prev);
        end
        // Captured values were cleared by reset.
        send_req = 1'b1;
        @(negedge CLK_50);
        send_req = 1'b0;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=00000000 T=0000\015\012") begin
            errors++; $display("FAIL midrst_zero_msg ok %0d got %s", ok, got);
        end
        wait_done(prev, ok);
        cycle_count = 32'hCAFE0123; hund_seconds = 13'd999; finished = 1'b1;
        recv_report(1'b0, got, ok);
        checks++;
        if (!ok || got != "C=CAFE0123 T=0999\015\012") begin
            errors++; $display("FAIL midrst_fresh_msg ok %0d got %s", ok, got);
        end
        wait_done(prev + 1, ok);
        checks++;
        if (!ok || done_cnt != prev + 2) begin
            errors++; $display("FAIL midrst_done got %0d want 2", done_cnt - prev);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_and_small();
        test_busy_ignore();
        test_resend();
        test_simultaneous();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
